// File: rtl/booth_coef_encoder.sv
`default_nettype none
// ============================================================================
// Module      : booth_coef_encoder
// Description : Sequential radix-4 Booth recoder. Accepts one signed
//               coefficient per transaction and emits its Booth digits,
//               LSB digit first, as {inv, shift[1:0]} select codes.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_coef_encoder #(
    parameter  int COEF_W  = 8,
    localparam int c_NDIG  = COEF_W / 2,
    localparam int c_IDX_W = (c_NDIG > 1) ? $clog2(c_NDIG) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEF_W-1:0]  in_coef,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_sel,
    output logic [c_IDX_W-1:0] out_idx,
    output logic               out_last
);

    localparam logic [0:0]         c_ST_IDLE  = 1'b0;
    localparam logic [0:0]         c_ST_RUN   = 1'b1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NDIG - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [COEF_W:0]    r_sr;
    logic [c_IDX_W-1:0] r_cnt;
    logic [2:0]         w_sel;
    logic               w_run;
    logic               w_last;
    logic               w_in_fire;
    logic               w_out_fire;

    assign w_run      = (r_state == c_ST_RUN);
    assign w_last     = w_run && (r_cnt == c_LAST_IDX);
    // A new coefficient may enter on the cycle the final digit leaves,
    // which is what gives gap-free back-to-back throughput.
    assign in_ready   = !clr && (!w_run || (w_last && out_ready));
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = w_run && out_ready;

    assign out_valid  = w_run;
    assign out_idx    = r_cnt;
    assign out_last   = w_last;
    assign out_sel    = w_run ? w_sel : 3'b000;

    // Map the current Booth triplet (b[2i+1], b[2i], b[2i-1]) to a select code
    always_comb begin
        w_sel = 3'b000;
        case (r_sr[2:0])
            3'b000:  w_sel = 3'b000; //  0
            3'b001:  w_sel = 3'b001; // +1
            3'b010:  w_sel = 3'b001; // +1
            3'b011:  w_sel = 3'b010; // +2
            3'b100:  w_sel = 3'b110; // -2
            3'b101:  w_sel = 3'b101; // -1
            3'b110:  w_sel = 3'b101; // -1
            3'b111:  w_sel = 3'b000; //  0
            default: w_sel = 3'b000;
        endcase
    end

    // Next-state logic; clr takes priority over both handshakes
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = c_ST_IDLE;
        end else if (w_in_fire) begin
            w_state_nxt = c_ST_RUN;
        end else if (w_out_fire && w_last) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift register and digit counter: load on accept, advance on each digit handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_in_fire) begin
            r_sr  <= {in_coef, 1'b0};
            r_cnt <= '0;
        end else if (w_out_fire) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_sr  <= {{2{r_sr[COEF_W]}}, r_sr[COEF_W:2]};
                r_cnt <= r_cnt + c_IDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_coef_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_coef_encoder
// Description : Directed self-checking bench for booth_coef_encoder (COEF_W=8)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_coef_encoder;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_coef;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_sel;
    logic [1:0] out_idx;
    logic       out_last;

    int n_total;
    int n_bad;

    booth_coef_encoder #(.COEF_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a coefficient in IDLE and take the accept edge
    task automatic send(input string tag, input logic [7:0] coef);
        in_valid = 1'b1;
        in_coef  = coef;
        #1;
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        step();
        in_valid = 1'b0;
    endtask

    // Drain four digits with out_ready held high; exp = {d3, d2, d1, d0}
    task automatic collect(input string tag, input logic [11:0] exp);
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            #1;
            chk({tag, "_valid"}, int'(out_valid), 1);
            chk({tag, "_sel"},   int'(out_sel),   int'(exp[3*i +: 3]));
            chk({tag, "_idx"},   int'(out_idx),   i);
            chk({tag, "_last"},  int'(out_last),  (i == 3) ? 1 : 0);
            step();
        end
        #1;
        chk({tag, "_idle"}, int'(out_valid), 0);
    endtask

    // Select code to signed digit, straight from the code table
    function automatic int sel2dig(input logic [2:0] s, output bit bad_code);
        bad_code = 1'b0;
        case (s)
            3'b000:  return 0;
            3'b001:  return 1;
            3'b010:  return 2;
            3'b101:  return -1;
            3'b110:  return -2;
            default: begin bad_code = 1'b1; return 0; end
        endcase
    endfunction

    logic [3:0] pat;
    int         idx;
    int         sum;
    int         illegal;
    bit         bc;
    logic [7:0] v;

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_coef   = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) step();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sel",   int'(out_sel),   0);
        chk("rst_idx",   int'(out_idx),   0);
        chk("rst_last",  int'(out_last),  0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", int'(in_ready), 1);

        // 7 = -1 + 2*4
        send("c7", 8'd7);
        collect("c7", {3'b000, 3'b000, 3'b010, 3'b101});

        // -128 = -2*64
        send("c80", 8'h80);
        collect("c80", {3'b110, 3'b000, 3'b000, 3'b000});

        // -1
        send("cff", 8'hFF);
        collect("cff", {3'b000, 3'b000, 3'b000, 3'b101});

        // 85 with out_ready pattern 1,0,0,1 repeating
        pat = 4'b1001;
        send("c55", 8'h55);
        idx = 0;
        for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
            out_ready = pat[cyc % 4];
            #1;
            chk("c55_valid", int'(out_valid), 1);
            chk("c55_sel",   int'(out_sel),   1);
            chk("c55_idx",   int'(out_idx),   idx);
            chk("c55_in_ready", int'(in_ready), (idx == 3 && out_ready) ? 1 : 0);
            if (out_ready) idx++;
            step();
        end
        chk("c55_done", idx, 4);
        #1;
        chk("c55_idle", int'(out_valid), 0);

        // Back-to-back 7 then 0x80, in_valid held high
        in_valid  = 1'b1;
        in_coef   = 8'd7;
        out_ready = 1'b1;
        step();
        in_coef = 8'h80;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) in_valid = 1'b0;
            #1;
            chk("b2b_valid", int'(out_valid), 1);
            chk("b2b_idx",   int'(out_idx),   i % 4);
            if (i == 3) chk("b2b_in_ready", int'(in_ready), 1);
            if (i == 0) chk("b2b_sel0", int'(out_sel), 3'b101);
            if (i == 1) chk("b2b_sel1", int'(out_sel), 3'b010);
            if (i == 4) chk("b2b_sel4", int'(out_sel), 3'b000);
            if (i == 7) chk("b2b_sel7", int'(out_sel), 3'b110);
            step();
        end
        #1;
        chk("b2b_idle", int'(out_valid), 0);

        // clr at digit 1 of 7, with a simultaneous offer and output handshake
        send("clr", 8'd7);
        out_ready = 1'b1;
        step();
        clr      = 1'b1;
        in_valid = 1'b1;
        in_coef  = 8'hFF;
        #1;
        chk("clr_idx1",     int'(out_idx),  1);
        chk("clr_in_ready", int'(in_ready), 0);
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr_valid", int'(out_valid), 0);
        chk("clr_idx",   int'(out_idx),   0);
        send("clr_ff", 8'hFF);
        collect("clr_ff", {3'b000, 3'b000, 3'b000, 3'b101});

        // Asynchronous reset mid-coefficient
        send("arst", 8'h55);
        out_ready = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_sel",   int'(out_sel),   0);
        chk("arst_idx",   int'(out_idx),   0);
        chk("arst_last",  int'(out_last),  0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_idle",     int'(out_valid), 0);

        // Exhaustive sweep against the recoding invariant
        for (int k = 0; k < 256; k++) begin
            v         = 8'(k);
            in_valid  = 1'b1;
            in_coef   = v;
            out_ready = 1'b1;
            #1;
            chk("sw_in_ready", int'(in_ready), 1);
            step();
            in_valid = 1'b0;
            sum      = 0;
            illegal  = 0;
            for (int i = 0; i < 4; i++) begin
                #1;
                chk("sw_valid", int'(out_valid), 1);
                chk("sw_idx",   int'(out_idx),   i);
                sum = sum + sel2dig(out_sel, bc) * (1 << (2 * i));
                if (bc) illegal++;
                step();
            end
            chk("sw_sum",     sum,     int'($signed(v)));
            chk("sw_illegal", illegal, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
